serial_io_expander: RTL and testbench

SERIAL_IO_EXPANDER -- requirements
Module: serial_io_expander

---
 rtl/serial_io_expander.sv | 175 +++++++++++++++++
 tb/tb_serial_io_expander.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_io_expander.sv
// Serial I/O expander: shifts a word out to a latch chain while reading a
// parallel-in chain over one shared serial clock.
module serial_io_expander #(
   parameter int WIDTH     = 16,
   parameter int DIV       = 4,
   parameter int MSB_FIRST = 1,
   parameter int MODE      = 0
) (
   input  logic             i_CLK,
   input  logic             i_RESET,
   input  logic [WIDTH-1:0] i_Data,
   input  logic             i_Start,
   input  logic             i_SerData,
   output logic             o_SerData,
   output logic             o_SerCLK,
   output logic             o_OutLatch,
   output logic             o_InLoad,
   output logic [WIDTH-1:0] o_Parallel,
   output logic             o_Valid,
   output logic             o_Busy
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH
   } state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    div_q, div_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [WIDTH-1:0] par_q, par_d;
   logic             sclk_q, sclk_d;
   logic             sdat_q, sdat_d;
   logic             latch_q, latch_d;
   logic             inld_q, inld_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             pend_q, pend_d;
   logic             first_q, first_d;

   logic             tick;
   logic             go;
   logic             tx_bit;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-1:0] rx_shift;

   assign tick = (div_q == DW'(DIV - 1));

   // A frame is due on every pass in continuous mode, otherwise only on
   // the first frame, a pending request or a changed word.
   assign go = (MODE == 0) || first_q || pend_q || (i_Data != last_q);

   assign tx_bit   = (MSB_FIRST != 0) ? tx_q[WIDTH-1] : tx_q[0];
   assign tx_shift = (MSB_FIRST != 0) ? {tx_q[WIDTH-2:0], 1'b0}
                                      : {1'b0, tx_q[WIDTH-1:1]};
   assign rx_shift = (MSB_FIRST != 0) ? {rx_q[WIDTH-2:0], i_SerData}
                                      : {i_SerData, rx_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + DW'(1);
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      last_d  = last_q;
      par_d   = par_q;
      sclk_d  = sclk_q;
      sdat_d  = sdat_q;
      latch_d = latch_q;
      inld_d  = inld_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      first_d = first_q;
      pend_d  = pend_q | i_Start;
      if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  state_d = LOAD;
                  inld_d  = 1'b0;
                  busy_d  = 1'b1;
                  tx_d    = i_Data;
                  last_d  = i_Data;
                  pend_d  = 1'b0;
                  first_d = 1'b0;
               end
            end
            LOAD: begin
               state_d = SHIFT;
               inld_d  = 1'b1;
               sdat_d  = tx_bit;
               tx_d    = tx_shift;
               cnt_d   = '0;
            end
            SHIFT: begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  rx_d   = rx_shift;
                  cnt_d  = cnt_q + CW'(1);
               end else begin
                  sclk_d = 1'b0;
                  if (cnt_q == CW'(WIDTH)) begin
                     state_d = LATCH;
                     sdat_d  = 1'b0;
                     latch_d = 1'b1;
                     par_d   = rx_q;
                     valid_d = 1'b1;
                  end else begin
                     sdat_d = tx_bit;
                     tx_d   = tx_shift;
                  end
               end
            end
            LATCH: begin
               state_d = IDLE;
               latch_d = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_CLK or negedge i_RESET) begin
      if (!i_RESET) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         last_q  <= '0;
         par_q   <= '0;
         sclk_q  <= 1'b0;
         sdat_q  <= 1'b0;
         latch_q <= 1'b0;
         inld_q  <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= 1'b0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         last_q  <= last_d;
         par_q   <= par_d;
         sclk_q  <= sclk_d;
         sdat_q  <= sdat_d;
         latch_q <= latch_d;
         inld_q  <= inld_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         first_q <= first_d;
      end
   end

   assign o_SerData  = sdat_q;
   assign o_SerCLK   = sclk_q;
   assign o_OutLatch = latch_q;
   assign o_InLoad   = inld_q;
   assign o_Parallel = par_q;
   assign o_Valid    = valid_q;
   assign o_Busy     = busy_q;

endmodule

// File: tb/tb_serial_io_expander.sv
// Bench for serial_io_expander: external chain models plus frame
// monitors, driven by directed and random steps.
module tb_serial_io_expander;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int errs = 0;
   int checks = 0;

   logic        rstA = 1'b1, rstB = 1'b1;
   logic [15:0] dataA, dataB, patA, patB;
   logic        startA, startB;
   logic        serinA, serinB;
   logic        sdatA, sclkA, latchA, inldA, validA, busyA;
   logic        sdatB, sclkB, latchB, inldB, validB, busyB;
   logic [15:0] parA, parB;
   logic [15:0] chainA, chainB;

   serial_io_expander dutA (
      .i_CLK(clk), .i_RESET(rstA), .i_Data(dataA),
      .i_Start(startA), .i_SerData(serinA),
      .o_SerData(sdatA), .o_SerCLK(sclkA),
      .o_OutLatch(latchA), .o_InLoad(inldA),
      .o_Parallel(parA), .o_Valid(validA), .o_Busy(busyA)
   );

   serial_io_expander #(
      .WIDTH(16), .DIV(4), .MSB_FIRST(0), .MODE(1)
   ) dutB (
      .i_CLK(clk), .i_RESET(rstB), .i_Data(dataB),
      .i_Start(startB), .i_SerData(serinB),
      .o_SerData(sdatB), .o_SerCLK(sclkB),
      .o_OutLatch(latchB), .o_InLoad(inldB),
      .o_Parallel(parB), .o_Valid(validB), .o_Busy(busyB)
   );

   // Parallel-in chains: load on strobe low, shift on serial clock rise.
   always @(negedge inldA or posedge sclkA)
      if (!inldA) chainA = patA;
      else chainA = {chainA[14:0], 1'b0};
   assign serinA = chainA[15];

   always @(negedge inldB or posedge sclkB)
      if (!inldB) chainB = patB;
      else chainB = {1'b0, chainB[15:1]};
   assign serinB = chainB[0];

   logic        bitsA[$];
   logic        bitsB[$];
   logic        psA = 0, plA = 0, piA = 1;
   logic        psB = 0, plB = 0, piB = 1;
   logic [15:0] wA, wB, frameA, frameB;
   logic        fbB;
   int nA = 0, nB = 0, latA = 0, latB = 0;
   int valA = 0, valB = 0, lsA = 0, latlenA = 0;
   int lastldA = 0, prevldA = 0;

   always @(negedge clk) begin
      if (!rstA) bitsA.delete();
      else begin
         if (sclkA && !psA) bitsA.push_back(sdatA);
         if (latchA && !plA) begin
            wA = '0;
            foreach (bitsA[i]) wA = {wA[14:0], bitsA[i]};
            frameA = wA;
            nA = bitsA.size();
            latA++;
            lsA = cyc;
            bitsA.delete();
         end
         if (!latchA && plA) latlenA = cyc - lsA;
         if (validA) valA++;
         if (!inldA && piA) begin
            prevldA = lastldA;
            lastldA = cyc;
         end
      end
      psA = sclkA; plA = latchA; piA = inldA;
   end

   always @(negedge clk) begin
      if (!rstB) bitsB.delete();
      else begin
         if (sclkB && !psB) bitsB.push_back(sdatB);
         if (latchB && !plB) begin
            wB = '0;
            foreach (bitsB[i]) if (i < 16) wB[i] = bitsB[i];
            frameB = wB;
            fbB = (bitsB.size() > 0) ? bitsB[0] : 1'b0;
            nB = bitsB.size();
            latB++;
            bitsB.delete();
         end
         if (validB) valB++;
      end
      psB = sclkB; plB = latchB; piB = inldB;
   end

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_lat_a(input int target, input string tag);
      int k = 0;
      while (latA < target && k < 2000) begin
         @(posedge clk); #2; k++;
      end
      chk(tag, 64'(latA >= target), 64'd1);
   endtask

   task automatic wait_lat_b(input int target, input string tag);
      int k = 0;
      while (latB < target && k < 2000) begin
         @(posedge clk); #2; k++;
      end
      chk(tag, 64'(latB >= target), 64'd1);
   endtask

   task automatic wait_bits_a(input int n, input string tag);
      int k = 0;
      while (bitsA.size() < n && k < 400) begin
         @(posedge clk); #2; k++;
      end
      chk(tag, 64'(bitsA.size() >= n), 64'd1);
   endtask

   task automatic wait_busy_b(input string tag);
      int k = 0;
      while (!busyB && k < 100) begin
         @(posedge clk); #2; k++;
      end
      chk(tag, 64'(busyB), 64'd1);
   endtask

   task automatic pulse_start_b();
      startB = 1'b1;
      @(posedge clk); #2;
      startB = 1'b0;
   endtask

   initial begin
      logic [15:0] d, p;
      int base, relA, vsave, lsave;
      dataA = 16'hA5C3; patA = 16'h1234; startA = 1'b0;
      dataB = 16'h0001; patB = 16'h8421; startB = 1'b0;
      #1;
      rstA = 1'b0;
      rstB = 1'b0;
      #20;
      chk("reset_A",
          64'({sclkA, sdatA, latchA, inldA, validA, busyA, parA}),
          64'({6'b000100, 16'h0000}));
      chk("reset_B",
          64'({sclkB, sdatB, latchB, inldB, validB, busyB, parB}),
          64'({6'b000100, 16'h0000}));

      // Continuous refresh, MSB first
      @(posedge clk); #2;
      rstA = 1'b1;
      relA = cyc;
      wait_lat_a(1, "lat1_timeout");
      chk("first_load", 64'(lastldA - relA), 64'd4);
      chk("frame_A5C3", 64'(frameA), 64'hA5C3);
      chk("nbits_A", 64'(nA), 64'd16);
      chk("par_1234", 64'(parA), 64'h1234);
      wait_lat_a(2, "lat2_timeout");
      chk("latch_len", 64'(latlenA), 64'd4);
      chk("period", 64'(lastldA - prevldA), 64'd140);
      chk("frame_rep", 64'(frameA), 64'hA5C3);

      for (int it = 0; it < 4; it++) begin
         d = 16'($urandom);
         p = 16'($urandom);
         dataA = d;
         patA = p;
         base = latA;
         wait_lat_a(base + 1, "rnd_lat_A");
         chk("rnd_frame_A", 64'(frameA), 64'(d));
         chk("rnd_par_A", 64'(parA), 64'(p));
      end

      // Data change mid-shift affects only the next frame
      base = latA;
      dataA = 16'hFFFF;
      wait_bits_a(5, "mid_shift");
      dataA = 16'h0000;
      wait_lat_a(base + 1, "ones_lat");
      chk("frame_ones", 64'(frameA), 64'hFFFF);
      wait_lat_a(base + 2, "zeros_lat");
      chk("frame_zeros", 64'(frameA), 64'h0000);

      // Asynchronous reset after the 7th serial clock rise
      base = latA;
      dataA = 16'h3C5A;
      patA = 16'hBEEF;
      wait_bits_a(7, "seven_rises");
      #1;
      rstA = 1'b0;
      #1;
      chk("reset_async",
          64'({sclkA, sdatA, latchA, inldA, validA, busyA, parA}),
          64'({6'b000100, 16'h0000}));
      vsave = valA;
      lsave = latA;
      repeat (100) @(posedge clk);
      #2;
      chk("abort_no_latch", 64'(latA), 64'(lsave));
      chk("abort_no_valid", 64'(valA), 64'(vsave));
      rstA = 1'b1;
      relA = cyc;
      wait_lat_a(lsave + 1, "restart_lat");
      chk("restart_load", 64'(lastldA - relA), 64'd4);
      chk("restart_frame", 64'(frameA), 64'h3C5A);
      chk("restart_nbits", 64'(nA), 64'd16);
      chk("restart_par", 64'(parA), 64'hBEEF);
      chk("valid_per_frame_A", 64'(valA), 64'(latA));

      // On-demand mode, LSB first
      @(posedge clk); #2;
      rstB = 1'b1;
      wait_lat_b(1, "lsb_lat");
      chk("lsb_first_bit", 64'(fbB), 64'd1);
      chk("lsb_frame", 64'(frameB), 64'h0001);
      chk("lsb_par", 64'(parB), 64'h8421);

      rstB = 1'b0;
      dataB = 16'h00FF;
      p = 16'($urandom);
      patB = p;
      repeat (5) @(posedge clk);
      #2;
      chk("reset_B2",
          64'({sclkB, sdatB, latchB, inldB, validB, busyB, parB}),
          64'({6'b000100, 16'h0000}));
      rstB = 1'b1;
      base = latB;
      wait_lat_b(base + 1, "m1_first_lat");
      chk("m1_frame_00FF", 64'(frameB), 64'h00FF);
      chk("m1_par", 64'(parB), 64'(p));
      repeat (600) @(posedge clk);
      #2;
      chk("m1_single", 64'(latB), 64'(base + 1));
      chk("m1_idle_busy", 64'(busyB), 64'd0);

      dataB = 16'h00FE;
      wait_busy_b("m1_change_busy");
      pulse_start_b();
      repeat (10) @(posedge clk);
      #2;
      pulse_start_b();
      wait_lat_b(base + 2, "m1_change_lat");
      chk("m1_frame_00FE", 64'(frameB), 64'h00FE);
      wait_lat_b(base + 3, "m1_start_lat");
      chk("m1_start_frame", 64'(frameB), 64'h00FE);
      repeat (600) @(posedge clk);
      #2;
      chk("m1_start_once", 64'(latB), 64'(base + 3));
      chk("m1_busy_low", 64'(busyB), 64'd0);

      // Change that reverts within a frame triggers nothing extra
      pulse_start_b();
      wait_busy_b("m1_revert_busy");
      dataB = 16'h1234;
      repeat (20) @(posedge clk);
      #2;
      dataB = 16'h00FE;
      repeat (600) @(posedge clk);
      #2;
      chk("m1_revert", 64'(latB), 64'(base + 4));

      for (int it = 0; it < 3; it++) begin
         d = 16'($urandom);
         if (d == dataB) d = d ^ 16'h0001;
         p = 16'($urandom);
         dataB = d;
         patB = p;
         base = latB;
         wait_lat_b(base + 1, "rnd_lat_B");
         chk("rnd_frame_B", 64'(frameB), 64'(d));
         chk("rnd_par_B", 64'(parB), 64'(p));
      end
      chk("valid_per_frame_B", 64'(valB), 64'(latB));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
